fu_complete_arbiter: RTL

Arbitrates the functional-unit result outputs onto the NUM_CDB common-data-bus lanes each cycle. Sits between the FU array fed by issue_stage and the CDB consumers (RS wakeup, map table, ROB complete). Grants are combinational so a losing FU holds its result. CDB lanes are registered. Priority is round-robin with per-FU starvation override.

---
 rtl/fu_complete_arbiter_pkg.sv | 26 ++
 rtl/fu_complete_arbiter_rr_multi_select.sv | 49 ++++
 rtl/fu_complete_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fu_complete_arbiter_pkg.sv
// Shared definitions for the FU completion arbiter and its neighbours
// (issue_stage, CDB consumers).
//   NUM_FU / NUM_CDB / PRF_IDX_W / STARVE_LIMIT : arbiter sizing
//   cdb_packet_t : one registered CDB lane (valid, tag, data, source FU)
//   fu_sel_e     : FU select encoding; its value is the FU's request index
package fu_complete_arbiter_pkg;

  localparam int unsigned FU_SEL_W     = 3;
  localparam int unsigned NUM_FU       = 2 ** FU_SEL_W;
  localparam int unsigned NUM_CDB      = 3;
  localparam int unsigned PRF_IDX_W    = 6;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned FU_IDX_W     = $clog2(NUM_FU);

  typedef struct packed {
    logic                 valid;
    logic [PRF_IDX_W-1:0] tag;
    logic [31:0]          data;
    logic [FU_IDX_W-1:0]  fu;
  } cdb_packet_t;

  typedef enum logic [FU_SEL_W-1:0] {
    FuAlu0, FuAlu1, FuAlu2, FuMult0, FuMult1, FuLoad, FuStore, FuBranch
  } fu_sel_e;

endpackage

// File: rtl/fu_complete_arbiter_rr_multi_select.sv
// Rotating multi-pick selector.
//   req      : request vector
//   start    : first index scanned; scan order is start, start+1, ... mod N
//   limit    : maximum number of picks this cycle (<= K)
//   grant    : picked requesters as a bit vector
//   pick_idx : index of the k-th pick, in scan order
//   pick_vld : pick k exists
//   count    : number of picks
module fu_complete_arbiter_rr_multi_select #(
  parameter int unsigned N    = 8,
  parameter int unsigned K    = 3,
  parameter int unsigned IdxW = $clog2(N),
  parameter int unsigned CntW = $clog2(K + 1)
) (
  input  logic [N-1:0]            req,
  input  logic [IdxW-1:0]         start,
  input  logic [CntW-1:0]         limit,
  output logic [N-1:0]            grant,
  output logic [K-1:0][IdxW-1:0]  pick_idx,
  output logic [K-1:0]            pick_vld,
  output logic [CntW-1:0]         count
);

  always_comb begin
    logic [IdxW-1:0] idx;
    int              cnt;
    grant    = '0;
    pick_idx = '0;
    pick_vld = '0;
    idx      = '0;
    cnt      = 0;
    for (int i = 0; i < int'(N); i++) begin
      // N is a power of two, so truncation to IdxW bits is the mod-N wrap.
      idx = start + IdxW'(i);
      if (req[idx] && (cnt < int'(limit))) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < int'(K); k++) begin
          if (k == cnt) begin
            pick_idx[k] = idx;
            pick_vld[k] = 1'b1;
          end
        end
        cnt++;
      end
    end
    count = CntW'(cnt);
  end

endmodule

// File: rtl/fu_complete_arbiter.sv
// Functional-unit completion arbiter: routes up to NUM_CDB FU results per
// cycle onto the registered CDB lanes.
//   clock, reset            : clock, asynchronous active-low reset
//   fu_req/fu_tag/fu_data   : per-FU completed result
//   fu_grant/fu_stall       : combinational accept / hold back per FU
//   cdb_valid/tag/data/fu   : registered CDB lanes, one cycle after grant
// Starved FUs (age == STARVE_LIMIT) are picked first in ascending order, then
// the remaining requesters in round-robin order from rr_ptr.
module fu_complete_arbiter
  import fu_complete_arbiter_pkg::*;
(
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_FU-1:0]                  fu_req,
  input  logic [NUM_FU-1:0][PRF_IDX_W-1:0]   fu_tag,
  input  logic [NUM_FU-1:0][31:0]            fu_data,
  output logic [NUM_FU-1:0]                  fu_grant,
  output logic [NUM_FU-1:0]                  fu_stall,
  output logic [NUM_CDB-1:0]                 cdb_valid,
  output logic [NUM_CDB-1:0][PRF_IDX_W-1:0]  cdb_tag,
  output logic [NUM_CDB-1:0][31:0]           cdb_data,
  output logic [NUM_CDB-1:0][FU_IDX_W-1:0]   cdb_fu
);

  localparam int unsigned CntW = $clog2(NUM_CDB + 1);
  localparam int unsigned AgeW = $clog2(STARVE_LIMIT + 1);

  logic [FU_IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0][AgeW-1:0]       age_q, age_d;
  cdb_packet_t [NUM_CDB-1:0]         cdb_q, cdb_d;

  logic [NUM_FU-1:0]                 starved;
  logic [NUM_FU-1:0]                 p1_grant, p2_grant;
  logic [NUM_CDB-1:0][FU_IDX_W-1:0]  p1_idx, p2_idx;
  logic [NUM_CDB-1:0]                p1_vld, p2_vld;
  logic [CntW-1:0]                   p1_cnt, p2_cnt, p2_limit;

  always_comb begin
    starved = '0;
    for (int i = 0; i < int'(NUM_FU); i++) begin
      starved[i] = fu_req[i] && (age_q[i] == AgeW'(STARVE_LIMIT));
    end
  end

  fu_complete_arbiter_rr_multi_select #(
    .N (NUM_FU),
    .K (NUM_CDB)
  ) u_pass1 (
    .req      (starved),
    .start    ('0),
    .limit    (CntW'(NUM_CDB)),
    .grant    (p1_grant),
    .pick_idx (p1_idx),
    .pick_vld (p1_vld),
    .count    (p1_cnt)
  );

  assign p2_limit = CntW'(NUM_CDB) - p1_cnt;

  fu_complete_arbiter_rr_multi_select #(
    .N (NUM_FU),
    .K (NUM_CDB)
  ) u_pass2 (
    .req      (fu_req & ~p1_grant),
    .start    (rr_ptr_q),
    .limit    (p2_limit),
    .grant    (p2_grant),
    .pick_idx (p2_idx),
    .pick_vld (p2_vld),
    .count    (p2_cnt)
  );

  assign fu_grant = p1_grant | p2_grant;
  assign fu_stall = fu_req & ~fu_grant;

  // Lane k: pass-1 picks fill the low lanes, pass-2 picks follow.
  always_comb begin
    logic [FU_IDX_W-1:0] sel;
    logic                hit;
    cdb_d = '0;
    sel   = '0;
    hit   = 1'b0;
    for (int k = 0; k < int'(NUM_CDB); k++) begin
      sel = p1_idx[k];
      hit = p1_vld[k];
      for (int j = 0; j < int'(NUM_CDB); j++) begin
        if (!p1_vld[k] && p2_vld[j] && ((j + int'(p1_cnt)) == k)) begin
          sel = p2_idx[j];
          hit = 1'b1;
        end
      end
      if (hit) begin
        cdb_d[k].valid = 1'b1;
        cdb_d[k].tag   = fu_tag[sel];
        cdb_d[k].data  = fu_data[sel];
        cdb_d[k].fu    = sel;
      end
    end
  end

  // Pointer moves just past the last round-robin winner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (p2_cnt != '0) begin
      for (int j = 0; j < int'(NUM_CDB); j++) begin
        if (p2_vld[j]) rr_ptr_d = p2_idx[j] + FU_IDX_W'(1);
      end
    end
  end

  always_comb begin
    age_d = '0;
    for (int i = 0; i < int'(NUM_FU); i++) begin
      if (fu_stall[i]) begin
        age_d[i] = (age_q[i] == AgeW'(STARVE_LIMIT)) ? age_q[i] : age_q[i] + AgeW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      age_q    <= '0;
      cdb_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      age_q    <= age_d;
      cdb_q    <= cdb_d;
    end
  end

  always_comb begin
    for (int k = 0; k < int'(NUM_CDB); k++) begin
      cdb_valid[k] = cdb_q[k].valid;
      cdb_tag[k]   = cdb_q[k].tag;
      cdb_data[k]  = cdb_q[k].data;
      cdb_fu[k]    = cdb_q[k].fu;
    end
  end

endmodule
